// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue stage: ALU control codes, opcode/funct
// constants, operand/forward selects and the ID/EX register payload.
package alu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 3;
  localparam int unsigned SHW    = 5;
  localparam int unsigned IMMW   = 16;

  localparam logic [CTRL_W-1:0] ALU_AND = 3'b000;
  localparam logic [CTRL_W-1:0] ALU_OR  = 3'b001;
  localparam logic [CTRL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [CTRL_W-1:0] ALU_XOR = 3'b011;
  localparam logic [CTRL_W-1:0] ALU_SLL = 3'b100;
  localparam logic [CTRL_W-1:0] ALU_SRL = 3'b101;
  localparam logic [CTRL_W-1:0] ALU_SUB = 3'b110;
  localparam logic [CTRL_W-1:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_SLT  = 6'b101010;

  typedef enum logic [1:0] {
    ASEL_RS       = 2'b00,
    ASEL_SHAMT    = 2'b01,
    ASEL_RS_SHIFT = 2'b10
  } asel_e;

  typedef enum logic {
    BSEL_RT  = 1'b0,
    BSEL_IMM = 1'b1
  } bsel_e;

  typedef enum logic [1:0] {
    FWD_REG     = 2'b00,
    FWD_RESULTW = 2'b01,
    FWD_ALUOUTM = 2'b10,
    FWD_REG_ALT = 2'b11
  } fwd_e;

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    asel_e             asel;
    bsel_e             bsel;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   rs;
    logic [XLEN-1:0]   rt;
    logic [XLEN-1:0]   imm;
  } idex_t;

  localparam idex_t IDEX_BUBBLE = '{
    valid: 1'b0,
    ctrl:  ALU_ADD,
    asel:  ASEL_RS,
    bsel:  BSEL_RT,
    shamt: '0,
    rs:    '0,
    rt:    '0,
    imm:   '0
  };

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode/funct decoder producing ALU control, operand selects,
// immediate-extension mode and the illegal-instruction flag.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [1:0]        asel,
  output logic              bsel,
  output logic              sign_ext,
  output logic              illegal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    asel     = ASEL_RS;
    bsel     = BSEL_RT;
    sign_ext = 1'b1;
    illegal  = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU: alu_ctrl = ALU_ADD;
          F_SUB, F_SUBU: alu_ctrl = ALU_SUB;
          F_AND:         alu_ctrl = ALU_AND;
          F_OR:          alu_ctrl = ALU_OR;
          F_XOR:         alu_ctrl = ALU_XOR;
          F_SLT:         alu_ctrl = ALU_SLT;
          F_SLL: begin
            alu_ctrl = ALU_SLL;
            asel     = ASEL_SHAMT;
          end
          F_SRL: begin
            alu_ctrl = ALU_SRL;
            asel     = ASEL_SHAMT;
          end
          F_SLLV: begin
            alu_ctrl = ALU_SLL;
            asel     = ASEL_RS_SHIFT;
          end
          F_SRLV: begin
            alu_ctrl = ALU_SRL;
            asel     = ASEL_RS_SHIFT;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_LW, OP_SW, OP_ADDI, OP_ADDIU: begin
        alu_ctrl = ALU_ADD;
        bsel     = BSEL_IMM;
      end
      OP_ANDI: begin
        alu_ctrl = ALU_AND;
        bsel     = BSEL_IMM;
        sign_ext = 1'b0;
      end
      OP_ORI: begin
        alu_ctrl = ALU_OR;
        bsel     = BSEL_IMM;
        sign_ext = 1'b0;
      end
      OP_XORI: begin
        alu_ctrl = ALU_XOR;
        bsel     = BSEL_IMM;
        sign_ext = 1'b0;
      end
      OP_SLTI: begin
        alu_ctrl = ALU_SLT;
        bsel     = BSEL_IMM;
      end
      OP_BEQ, OP_BNE: alu_ctrl = ALU_SUB;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decode, ID/EX register with flush/stall, EX forwarding muxes.
// Optional illegal-instruction counter enabled by ALU_ILLEGAL_CNT_EN.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ValidD,
  input  logic [5:0]       OpD,
  input  logic [5:0]       FunctD,
  input  logic [4:0]       ShamtD,
  input  logic [15:0]      ImmD,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [WIDTH-1:0] ResultW,
  input  logic [WIDTH-1:0] ALUOutM,
  output logic             ValidE,
  output logic [2:0]       ALUControlE,
  output logic [WIDTH-1:0] SrcAE,
  output logic [WIDTH-1:0] SrcBE,
  output logic [WIDTH-1:0] WriteDataE,
  output logic             IllegalD
`ifdef ALU_ILLEGAL_CNT_EN
  ,
  output logic [15:0]      IllegalCnt
`endif
);

  logic [CTRL_W-1:0] dec_ctrl;
  logic [1:0]        dec_asel;
  logic              dec_bsel;
  logic              dec_sign_ext;
  logic              dec_illegal;

  idex_t           d_next;
  idex_t           e_q;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;

  alu_ctrl_decode u_decode (
    .op       (OpD),
    .funct    (FunctD),
    .alu_ctrl (dec_ctrl),
    .asel     (dec_asel),
    .bsel     (dec_bsel),
    .sign_ext (dec_sign_ext),
    .illegal  (dec_illegal)
  );

  assign IllegalD = ValidD & dec_illegal;

  // Next ID/EX payload; invalid or undecodable instructions become bubbles
  always_comb begin
    d_next = IDEX_BUBBLE;
    if (ValidD && !dec_illegal) begin
      d_next.valid = 1'b1;
      d_next.ctrl  = dec_ctrl;
      d_next.asel  = asel_e'(dec_asel);
      d_next.bsel  = bsel_e'(dec_bsel);
      d_next.shamt = ShamtD;
      d_next.rs    = RD1D;
      d_next.rt    = RD2D;
      d_next.imm   = dec_sign_ext ? {{(XLEN-IMMW){ImmD[IMMW-1]}}, ImmD}
                                  : {{(XLEN-IMMW){1'b0}}, ImmD};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      e_q <= IDEX_BUBBLE;
    end else if (!StallE) begin
      e_q <= d_next;
    end
  end

  // EX-side forwarding on the rs/rt paths; a bubble forces all operands to 0
  always_comb begin
    fwd_a = e_q.rs;
    case (fwd_e'(ForwardAE))
      FWD_RESULTW: fwd_a = ResultW;
      FWD_ALUOUTM: fwd_a = ALUOutM;
      default:     fwd_a = e_q.rs;
    endcase
    fwd_b = e_q.rt;
    case (fwd_e'(ForwardBE))
      FWD_RESULTW: fwd_b = ResultW;
      FWD_ALUOUTM: fwd_b = ALUOutM;
      default:     fwd_b = e_q.rt;
    endcase

    SrcAE      = '0;
    SrcBE      = '0;
    WriteDataE = '0;
    if (e_q.valid) begin
      case (e_q.asel)
        ASEL_SHAMT:    SrcAE = {{(XLEN-SHW){1'b0}}, e_q.shamt};
        ASEL_RS_SHIFT: SrcAE = {{(XLEN-SHW){1'b0}}, fwd_a[SHW-1:0]};
        default:       SrcAE = fwd_a;
      endcase
      SrcBE      = (e_q.bsel == BSEL_IMM) ? e_q.imm : fwd_b;
      WriteDataE = fwd_b;
    end
  end

  assign ValidE      = e_q.valid;
  assign ALUControlE = e_q.ctrl;

`ifdef ALU_ILLEGAL_CNT_EN
  // Saturating count of issued illegal instructions; flushes still count
  always_ff @(posedge clk) begin
    if (reset) begin
      IllegalCnt <= '0;
    end else if (IllegalD && !StallE && (IllegalCnt != 16'hFFFF)) begin
      IllegalCnt <= IllegalCnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: expected EX outputs are queued at issue
// and compared after the clock edge; forwarding, stall, flush and reset directed.
module tb_alu_issue_stage;

  typedef struct {
    logic        valid;
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] wd;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        ValidD;
  logic [5:0]  OpD;
  logic [5:0]  FunctD;
  logic [4:0]  ShamtD;
  logic [15:0] ImmD;
  logic [31:0] RD1D, RD2D;
  logic        StallE, FlushE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW, ALUOutM;
  logic        ValidE;
  logic [2:0]  ALUControlE;
  logic [31:0] SrcAE, SrcBE, WriteDataE;
  logic        IllegalD;
`ifdef ALU_ILLEGAL_CNT_EN
  logic [15:0] IllegalCnt;
`endif

  int   checks   = 0;
  int   failures = 0;
  int   exp_cnt  = 0;
  exp_t sb_q[$];

  // {opcode, funct} pairs; funct ignored for I-type
  logic [11:0] insn_tbl [20] = '{
    {6'h00, 6'h20}, {6'h00, 6'h21}, {6'h00, 6'h22}, {6'h00, 6'h23},
    {6'h00, 6'h24}, {6'h00, 6'h25}, {6'h00, 6'h26}, {6'h00, 6'h2a},
    {6'h00, 6'h00}, {6'h00, 6'h02}, {6'h00, 6'h04}, {6'h00, 6'h06},
    {6'h23, 6'h11}, {6'h2b, 6'h00}, {6'h08, 6'h3f}, {6'h0c, 6'h00},
    {6'h0d, 6'h00}, {6'h0e, 6'h00}, {6'h0a, 6'h00}, {6'h04, 6'h00}
  };

  alu_issue_stage #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .ValidD      (ValidD),
    .OpD         (OpD),
    .FunctD      (FunctD),
    .ShamtD      (ShamtD),
    .ImmD        (ImmD),
    .RD1D        (RD1D),
    .RD2D        (RD2D),
    .StallE      (StallE),
    .FlushE      (FlushE),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .ResultW     (ResultW),
    .ALUOutM     (ALUOutM),
    .ValidE      (ValidE),
    .ALUControlE (ALUControlE),
    .SrcAE       (SrcAE),
    .SrcBE       (SrcBE),
    .WriteDataE  (WriteDataE),
    .IllegalD    (IllegalD)
`ifdef ALU_ILLEGAL_CNT_EN
    ,
    .IllegalCnt  (IllegalCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference decode assuming ForwardAE/BE = 00
  function automatic exp_t model(input logic vd, input logic [5:0] op, input logic [5:0] fn,
                                 input logic [4:0] sh, input logic [15:0] imm,
                                 input logic [31:0] rd1, input logic [31:0] rd2);
    exp_t e;
    logic ok;
    logic [2:0] c;
    logic [31:0] a, b, se, ze;
    se = {{16{imm[15]}}, imm};
    ze = {16'h0000, imm};
    ok = 1'b1;
    c  = 3'b010;
    a  = rd1;
    b  = rd2;
    case (op)
      6'h00: begin
        case (fn)
          6'h20, 6'h21: c = 3'b010;
          6'h22, 6'h23: c = 3'b110;
          6'h24: c = 3'b000;
          6'h25: c = 3'b001;
          6'h26: c = 3'b011;
          6'h2a: c = 3'b111;
          6'h00: begin c = 3'b100; a = {27'd0, sh}; end
          6'h02: begin c = 3'b101; a = {27'd0, sh}; end
          6'h04: begin c = 3'b100; a = {27'd0, rd1[4:0]}; end
          6'h06: begin c = 3'b101; a = {27'd0, rd1[4:0]}; end
          default: ok = 1'b0;
        endcase
      end
      6'h23, 6'h2b, 6'h08, 6'h09: b = se;
      6'h0c: begin c = 3'b000; b = ze; end
      6'h0d: begin c = 3'b001; b = ze; end
      6'h0e: begin c = 3'b011; b = ze; end
      6'h0a: begin c = 3'b111; b = se; end
      6'h04, 6'h05: c = 3'b110;
      default: ok = 1'b0;
    endcase
    e.ill = vd && !ok;
    if (vd && ok) begin
      e.valid = 1'b1; e.ctrl = c; e.a = a; e.b = b; e.wd = rd2;
    end else begin
      e.valid = 1'b0; e.ctrl = 3'b010; e.a = '0; e.b = '0; e.wd = '0;
    end
    return e;
  endfunction

  task automatic tick();
    exp_t m;
    m = model(ValidD, OpD, FunctD, ShamtD, ImmD, RD1D, RD2D);
    if (reset) exp_cnt = 0;
    else if (m.ill && !StallE && exp_cnt < 65535) exp_cnt++;
    @(posedge clk);
    #1;
`ifdef ALU_ILLEGAL_CNT_EN
    check_val("illegal_cnt", 32'(IllegalCnt), 32'(exp_cnt));
`endif
  endtask

  task automatic check_out(input string tag, input exp_t e);
    check_val({tag, ".valid"}, 32'(ValidE), 32'(e.valid));
    check_val({tag, ".ctrl"}, 32'(ALUControlE), 32'(e.ctrl));
    check_val({tag, ".srca"}, SrcAE, e.a);
    check_val({tag, ".srcb"}, SrcBE, e.b);
    check_val({tag, ".wdata"}, WriteDataE, e.wd);
  endtask

  task automatic check_bubble(input string tag);
    exp_t e;
    e.valid = 1'b0; e.ctrl = 3'b010; e.a = '0; e.b = '0; e.wd = '0; e.ill = 1'b0;
    check_out(tag, e);
  endtask

  task automatic drive(input logic vd, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] sh, input logic [15:0] imm,
                       input logic [31:0] rd1, input logic [31:0] rd2);
    ValidD = vd; OpD = op; FunctD = fn; ShamtD = sh; ImmD = imm; RD1D = rd1; RD2D = rd2;
  endtask

  // Drive one instruction, queue its expectation, clock it into EX and compare
  task automatic issue(input string tag, input logic vd, input logic [5:0] op,
                       input logic [5:0] fn, input logic [4:0] sh, input logic [15:0] imm,
                       input logic [31:0] rd1, input logic [31:0] rd2);
    exp_t m;
    drive(vd, op, fn, sh, imm, rd1, rd2);
    #1;
    m = model(vd, op, fn, sh, imm, rd1, rd2);
    check_val({tag, ".illegal_d"}, 32'(IllegalD), 32'(m.ill));
    sb_q.push_back(m);
    tick();
    if (sb_q.size() == 0) begin
      check_val({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      m = sb_q.pop_front();
      check_out(tag, m);
    end
  endtask

  initial begin
    drive(1'b0, 6'h00, 6'h00, 5'd0, 16'h0, 32'h0, 32'h0);
    StallE = 1'b0; FlushE = 1'b0; ForwardBE = 2'b00; ResultW = '0;
    reset = 1'b1; ForwardAE = 2'b10; ALUOutM = 32'h0000DEAD;
    repeat (2) tick();
    check_bubble("reset");
    ForwardAE = 2'b00; ALUOutM = '0;
    reset = 1'b0;

    issue("sll",   1'b1, 6'h00, 6'h00, 5'd4, 16'h0, 32'h0, 32'h1);
    issue("sllv",  1'b1, 6'h00, 6'h04, 5'd9, 16'h0, 32'h23, 32'h7);
    issue("srlv",  1'b1, 6'h00, 6'h06, 5'd0, 16'h0, 32'hFFFFFFFF, 32'h80000000);
    issue("srl",   1'b1, 6'h00, 6'h02, 5'd31, 16'h0, 32'h12345678, 32'hF0);
    issue("andi",  1'b1, 6'h0c, 6'h00, 5'd0, 16'h8000, 32'h5, 32'h9);
    issue("addi",  1'b1, 6'h08, 6'h00, 5'd0, 16'h8000, 32'h5, 32'h9);
    issue("sw",    1'b1, 6'h2b, 6'h00, 5'd0, 16'hFFFC, 32'h100, 32'hCAFE);
    issue("bne",   1'b1, 6'h05, 6'h00, 5'd0, 16'h0010, 32'h3, 32'h4);
    issue("ill_fn", 1'b1, 6'h00, 6'h3f, 5'd0, 16'h0, 32'h1, 32'h2);
    issue("nvalid", 1'b0, 6'h00, 6'h20, 5'd0, 16'h0, 32'h1, 32'h2);

    for (int i = 0; i < 30; i++) begin
      logic [11:0] p;
      logic [5:0]  op;
      p  = insn_tbl[$urandom_range(0, 19)];
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : p[11:6];
      issue("rand", $urandom_range(0, 7) != 0, op, p[5:0], 5'($urandom_range(0, 31)),
            16'($urandom), $urandom, $urandom);
    end

    // Forwarding after the register
    issue("add", 1'b1, 6'h00, 6'h20, 5'd0, 16'h0, 32'h10, 32'h20);
    ForwardBE = 2'b01; ResultW = 32'h55; #1;
    check_val("fwd_b_resw.srcb", SrcBE, 32'h55);
    check_val("fwd_b_resw.wdata", WriteDataE, 32'h55);
    check_val("fwd_b_resw.srca", SrcAE, 32'h10);
    ForwardAE = 2'b10; ALUOutM = 32'h77; #1;
    check_val("fwd_a_alum.srca", SrcAE, 32'h77);
    ForwardAE = 2'b11; ForwardBE = 2'b11; #1;
    check_val("fwd_a_11.srca", SrcAE, 32'h10);
    check_val("fwd_b_11.srcb", SrcBE, 32'h20);
    ForwardAE = 2'b00; ForwardBE = 2'b00;
    issue("addi_f", 1'b1, 6'h08, 6'h00, 5'd0, 16'h0004, 32'h1, 32'h2);
    ForwardBE = 2'b01; ResultW = 32'h99; #1;
    check_val("fwd_imm.srcb", SrcBE, 32'h4);
    check_val("fwd_imm.wdata", WriteDataE, 32'h99);
    ForwardBE = 2'b00;
    issue("bubble", 1'b0, 6'h00, 6'h20, 5'd0, 16'h0, 32'h1, 32'h2);
    ForwardAE = 2'b10; ForwardBE = 2'b01; ALUOutM = 32'hDEAD; #1;
    check_bubble("bubble_fwd");
    ForwardAE = 2'b00; ForwardBE = 2'b00;

    // Stall holds E state while D changes
    issue("sub", 1'b1, 6'h00, 6'h22, 5'd0, 16'h0, 32'h100, 32'h30);
    StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'h0c, 6'h00, 5'd1, 16'($urandom), $urandom, $urandom);
      tick();
      check_val("stall.ctrl", 32'(ALUControlE), 32'h6);
      check_val("stall.srca", SrcAE, 32'h100);
      check_val("stall.srcb", SrcBE, 32'h30);
      check_val("stall.valid", 32'(ValidE), 32'd1);
    end
    ForwardAE = 2'b01; ResultW = 32'hABC; #1;
    check_val("stall_fwd.srca", SrcAE, 32'hABC);
    ForwardAE = 2'b00;
    FlushE = 1'b1;
    tick();
    check_bubble("flush_stall");
    FlushE = 1'b0; StallE = 1'b0;

    issue("sub2", 1'b1, 6'h00, 6'h23, 5'd0, 16'h0, 32'h7, 32'h3);
    StallE = 1'b1; reset = 1'b1;
    tick();
    check_bubble("reset_stall");
    reset = 1'b0; StallE = 1'b0;

    // Illegal opcodes; counter (when present) goes 0 -> 1 -> 2
    drive(1'b0, 6'h3f, 6'h00, 5'd0, 16'h0, 32'h1, 32'h2);
    #1;
    check_val("illegal_nvalid", 32'(IllegalD), 32'd0);
    issue("ill1", 1'b1, 6'h3f, 6'h00, 5'd0, 16'h0, 32'h1, 32'h2);
`ifdef ALU_ILLEGAL_CNT_EN
    check_val("cnt_one", 32'(IllegalCnt), 32'd1);
`endif
    issue("ill2", 1'b1, 6'h3f, 6'h20, 5'd0, 16'h0, 32'h1, 32'h2);
`ifdef ALU_ILLEGAL_CNT_EN
    check_val("cnt_two", 32'(IllegalCnt), 32'd2);
`endif
    StallE = 1'b1;
    tick();
    StallE = 1'b0; FlushE = 1'b1;
    tick();
    check_val("ill_flush.valid", 32'(ValidE), 32'd0);
    FlushE = 1'b0;
    issue("after", 1'b1, 6'h0d, 6'h00, 5'd0, 16'hF00F, 32'h0F0, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-to-execute issue stage of the pipelined core. It decodes opcode/funct into the 3-bit ALU control code and registers operands and control in the ID/EX pipeline register, with stall, flush and bubble handling. It drives the execute-stage ALU from EX-side forwarding muxes. It is the producer side of the ALU's SrcA/SrcB/ALUControl interface.

## Interface
Parameters:
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ValidD  in  1  the ID stage holds a real instruction.
- OpD  in  6  opcode field.
- FunctD  in  6  funct field.
- ShamtD  in  5  shift-amount field.
- ImmD  in  16  raw immediate field.
- RD1D, RD2D  in  32  register-file read data (rs, rt).
- StallE  in  1  hold the ID/EX register.
- FlushE  in  1  load a bubble.
- ForwardAE, ForwardBE  in  2  forwarding select: 00 = register, 01 = ResultW, 10 = ALUOutM, 11 = register.
- ResultW, ALUOutM  in  32  forwarded values.
- ValidE  out  1  the EX stage holds a real ALU operation.
- ALUControlE  out  3  ALU control code.
- SrcAE, SrcBE  out  32  ALU operands.
- WriteDataE  out  32  forwarded rt, used for stores.
- IllegalD  out  1  combinational: ValidD is high and the opcode/funct pair is undecodable.

## Operation
- ALU control codes: 010 ADD, 110 SUB, 000 AND, 001 OR, 011 XOR, 111 SLT, 100 SLL (SrcB<<SrcA), 101 SRL (SrcB>>SrcA).
- R-type decode (OpD=000000), by funct:
  - 100000/100001 → ADD; 100010/100011 → SUB; 100100 → AND; 100101 → OR; 100110 → XOR; 101010 → SLT.
  - 000000 → SLL, SrcA = shamt; 000010 → SRL, SrcA = shamt.
  - 000100 → SLL, SrcA = rs[4:0]; 000110 → SRL, SrcA = rs[4:0].
  - Upper 27 bits of a shift SrcA are forced to 0.
- I-type decode:
  - 100011 (lw), 101011 (sw), 001000, 001001 → ADD with sign-extended imm.
  - 001100 → AND, 001101 → OR, 001110 → XOR, all with zero-extended imm.
  - 001010 → SLT with sign-extended imm.
  - 000100 (beq), 000101 (bne) → SUB, SrcB = rt.
- Any other opcode/funct is illegal: IllegalD=1 and the stage loads a bubble.
- Register a per-instruction operand selector (rs, shamt, rt, imm). The forwarding muxes are applied after the register, on the rs and rt paths only.
- Bubble: ValidE=0, ALUControlE=010, SrcAE=SrcBE=WriteDataE=0 regardless of forwarding selects. The ALU then produces 0.

## Timing
- Latency: one cycle from D inputs to E outputs. Forwarding muxes are combinational in EX.
- Per-edge priority: reset > FlushE > StallE > load.
  - reset or FlushE: load a bubble.
  - StallE: hold all E state. Forwarded SrcAE/SrcBE may still change with the forwarding inputs.
  - Otherwise: load the decoded instruction, or a bubble if ValidD=0 or IllegalD=1.
- Reset values: ValidE=0, ALUControlE=010, SrcAE=SrcBE=WriteDataE=0.
- Reset asserted mid-stall clears the register in the same cycle.
- ForwardAE/BE=11 is treated as 00.

## Configuration
- ALU_ILLEGAL_CNT_EN defined:
  - Adds output IllegalCnt (16 bits), reset to 0.
  - Increments on each edge where IllegalD=1 and StallE=0, saturating at 0xFFFF.
  - Flush in the same cycle still counts.
- ALU_ILLEGAL_CNT_EN undefined: no port and no counter logic.

## Structure
- Shared package alu_pkg holds:
  - ALU control code localparams (ALU_ADD, ALU_SUB, ...).
  - Opcode and funct constants.
  - Operand-select and forward-select encodings.
- Sub-module alu_ctrl_decode: purely combinational decoder from OpD/FunctD to ALU control, operand selects, immediate-extension mode and illegal flag. Registering and forwarding stay in alu_issue_stage.

## Test plan
- Reset held for 2 cycles with ForwardAE=10 and ALUOutM=0xDEAD → ValidE=0, ALUControlE=010, SrcAE=0.
- sll (funct 000000, shamt=4), RD2D=0x1 → next cycle ALUControlE=100, SrcAE=4, SrcBE=0x1.
- sllv with RD1D=0x23 → SrcAE=3.
- andi with ImmD=0x8000 → SrcBE=0x00008000. addi with ImmD=0x8000 → SrcBE=0xFFFF8000, ALUControlE=010.
- add loaded, then ForwardBE=01 with ResultW=0x55 → SrcBE=0x55.
- StallE=1 for 3 cycles holds ALUControlE while D inputs change.
- FlushE and StallE both high → bubble.
- OpD=111111 → IllegalD=1, next cycle ValidE=0. With ALU_ILLEGAL_CNT_EN, IllegalCnt increments 0→1, and to 2 on a second illegal instruction.
